// File: rtl/pkt_sram_tx.sv
// Streams a stored packet from the 72-bit packet SRAM onto the user datapath,
// using a 2-entry output buffer so the stream keeps going under backpressure.
//
// state  | meaning
// S_IDLE | waiting for start; first/last address latched on accept
// S_RUN  | issuing SRAM reads and emitting buffered words
// S_DONE | single cycle, done (and eop_err if the last ctrl was 0) pulsed
module pkt_sram_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            first_addr,
  input  logic [ADDR_WIDTH-1:0]            last_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             eop_err,
  output logic [ADDR_WIDTH:0]              word_count,
  output logic                             sram_rd,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] sram_dout,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy
);

  localparam int WW = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   pkt_len;
  logic [ADDR_WIDTH:0]   rd_issued;
  logic [ADDR_WIDTH:0]   wc;
  logic                  rd_pending;
  logic [1:0]            buf_cnt;
  logic [WW-1:0]         buf_head;
  logic [WW-1:0]         buf_tail;
  logic                  eop_flag;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  last_pop;
  logic                  issue;
  logic [1:0]            occ;

  assign accept   = (state == S_IDLE) && start;
  assign push     = rd_pending;
  assign pop      = (buf_cnt != 2'd0) && out_rdy;
  assign last_pop = pop && ((wc + CNT_ONE) == pkt_len);

  // Occupancy counts words already buffered plus the one returning from SRAM,
  // so a read is only issued when its data is guaranteed a free slot.
  always_comb begin
    occ   = buf_cnt + {1'b0, rd_pending} - {1'b0, pop};
    issue = (state == S_RUN) && (rd_issued != pkt_len) && (occ < 2'd2);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_addr    <= '0;
      pkt_len    <= '0;
      rd_issued  <= '0;
      wc         <= '0;
      rd_pending <= 1'b0;
      buf_cnt    <= 2'd0;
      buf_head   <= '0;
      buf_tail   <= '0;
      eop_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= issue;
      if (accept) begin
        rd_addr   <= first_addr;
        pkt_len   <= {1'b0, last_addr - first_addr} + CNT_ONE;
        rd_issued <= '0;
        wc        <= '0;
        eop_flag  <= 1'b0;
      end
      if (issue) begin
        rd_addr   <= rd_addr + 1'b1;
        rd_issued <= rd_issued + CNT_ONE;
      end
      if (pop) wc <= wc + CNT_ONE;
      if (last_pop) eop_flag <= (buf_head[WW-1:DATA_WIDTH] == '0);
      unique case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf_head <= sram_dout;
          else                 buf_tail <= sram_dout;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_head <= sram_dout;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= sram_dout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign eop_err    = done && eop_flag;
  assign word_count = wc;
  assign sram_rd    = issue;
  assign sram_addr  = rd_addr;
  assign out_wr     = pop;
  assign out_data   = buf_head[DATA_WIDTH-1:0];
  assign out_ctrl   = buf_head[WW-1:DATA_WIDTH];

endmodule

// File: tb/tb_pkt_sram_tx.sv
// Directed bench for pkt_sram_tx: a behavioural SRAM with known contents,
// packets driven one at a time, every stream word and pulse checked in place.
module tb_pkt_sram_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  first_addr;
  logic [7:0]  last_addr;
  logic        busy;
  logic        done;
  logic        eop_err;
  logic [8:0]  word_count;
  logic        sram_rd;
  logic [7:0]  sram_addr;
  logic [71:0] sram_dout;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] mem [256];

  pkt_sram_tx #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .eop_err(eop_err), .word_count(word_count),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  initial sram_dout = '0;
  always @(posedge clk) if (sram_rd) sram_dout <= mem[sram_addr];

  // Stored word at address a: ctrl is a^0x20 (so address 0x20 has ctrl 0).
  function automatic logic [71:0] word_at(input logic [7:0] a);
    return {a ^ 8'h20, 32'hCAFE_F00D, 24'h000000, a};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one packet from start to done. bp selects the 1,0,0 out_rdy pattern,
  // timed checks exact cycle positions, inject_cyc (>0) pulses a rogue start.
  task automatic stream(input logic [7:0] f, input logic [7:0] l, input bit bp,
                        input bit timed, input int inject_cyc);
    logic [7:0] d;
    logic [7:0] ea;
    int n;
    int rd_cnt;
    int wr_cnt;
    bit got_done;
    bit exp_eop;
    d = l - f;
    n = int'(d) + 1;
    exp_eop = (l == 8'h20);
    rd_cnt = 0;
    wr_cnt = 0;
    got_done = 1'b0;
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    next_cycle();
    for (int cyc = 1; cyc < n * 4 + 20 && !got_done; cyc++) begin
      out_rdy = bp ? (cyc % 3 == 1) : 1'b1;
      if (cyc == inject_cyc) begin
        start = 1'b1;
        first_addr = f + 8'h33;
        last_addr = l + 8'h40;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (sram_rd) begin
        ea = f + rd_cnt[7:0];
        chk("rd_addr", sram_addr, ea);
        rd_cnt++;
        chk("rd_bound", rd_cnt <= n, 1);
      end
      if (timed) begin
        chk("rd_timing", sram_rd, cyc <= n);
        chk("wr_timing", out_wr, (cyc >= 3) && (cyc <= n + 2));
        chk("done_timing", done, cyc == n + 3);
      end
      if (!out_rdy) chk("wr_without_rdy", out_wr, 0);
      if (out_wr) begin
        ea = f + wr_cnt[7:0];
        chk("word", {out_ctrl, out_data}, word_at(ea));
        wr_cnt++;
      end
      chk("occupancy", (rd_cnt - wr_cnt) <= 2, 1);
      chk("busy", busy, 1);
      chk("eop_err", eop_err, done && exp_eop);
      if (done) begin
        got_done = 1'b1;
        chk("words_at_done", wr_cnt, n);
        chk("reads_at_done", rd_cnt, n);
        chk("word_count", word_count, n);
      end
      next_cycle();
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_once", done, 0);
    chk("word_count_hold", word_count, n);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_at(i[7:0]);
    rst_n = 1'b0;
    start = 1'b0;
    first_addr = 8'h00;
    last_addr = 8'h00;
    out_rdy = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eop_err", eop_err, 0);
    chk("rst_sram_rd", sram_rd, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    stream(8'h10, 8'h13, 1'b0, 1'b1, 0);  // basic 4-word, exact timing
    stream(8'h20, 8'h20, 1'b0, 1'b1, 0);  // 1-word, ctrl 0 -> eop_err
    stream(8'hFE, 8'h01, 1'b0, 1'b1, 0);  // address wrap
    stream(8'h30, 8'h37, 1'b1, 1'b0, 0);  // backpressure 1,0,0
    stream(8'h60, 8'h64, 1'b0, 1'b1, 3);  // ignored start mid-run
    stream(8'h05, 8'h04, 1'b0, 1'b1, 0);  // full-memory 256 words

    // Reset asserted while the third word is on the stream.
    start = 1'b1;
    first_addr = 8'h40;
    last_addr = 8'h45;
    out_rdy = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (cyc == 5) rst_n = 1'b0;
      @(negedge clk);
      if (cyc == 5) begin
        chk("rst_mid_word3_wr", out_wr, 1);
        chk("rst_mid_word3", {out_ctrl, out_data}, word_at(8'h42));
      end
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_eop_err", eop_err, 0);
    chk("rstm_sram_rd", sram_rd, 0);
    chk("rstm_out_wr", out_wr, 0);
    chk("rstm_sram_addr", sram_addr, 0);
    chk("rstm_word_count", word_count, 0);
    chk("rstm_out_data", out_data, 0);
    chk("rstm_out_ctrl", out_ctrl, 0);
    next_cycle();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      chk("rstm_no_done", done, 0);
      chk("rstm_idle", busy, 0);
      next_cycle();
    end
    stream(8'h50, 8'h52, 1'b0, 1'b1, 0);  // clean run after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_sram_tx.md
# pkt_sram_tx

Packet transmitter that reads a stored packet out of the shared 72-bit packet SRAM (ctrl in bits 71:64, data in bits 63:0) and drives it onto the NetFPGA user-datapath stream (`out_data`/`out_ctrl`/`out_wr`/`out_rdy`). The processor or the capture FIFO supplies a start command with the packet's first and last SRAM addresses. The block streams every word in that range, in address order, with full backpressure support. It then pulses `done` so the buffer can be released for reuse.

## Interface
- `DATA_WIDTH`, 64, stream data width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`, stream ctrl width.
- `ADDR_WIDTH`, 8, SRAM address width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  command strobe; sampled only when idle.
- `first_addr`  in  ADDR_WIDTH  address of the packet's first word; captured on an accepted `start`.
- `last_addr`  in  ADDR_WIDTH  address of the packet's last word; captured on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle pulse after the last word has been transferred.
- `eop_err`  out  1  one-cycle pulse with `done` when the last word's ctrl is 0.
- `word_count`  out  ADDR_WIDTH+1  words transferred in the current or last packet.
- `sram_rd`  out  1  SRAM read enable.
- `sram_addr`  out  ADDR_WIDTH  SRAM read address.
- `sram_dout`  in  CTRL_WIDTH+DATA_WIDTH  SRAM read data; valid 1 cycle after `sram_rd`.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_ctrl`  out  CTRL_WIDTH  stream ctrl.
- `out_wr`  out  1  word valid and transferred this cycle.
- `out_rdy`  in  1  downstream can accept a word this cycle.

## Operation
- States:
  - IDLE: accepts `start`, latches `first_addr`/`last_addr`, clears `word_count`, then goes to RUN.
  - RUN: issues SRAM reads and emits words.
  - DONE: one cycle; `done` is high; returns to IDLE.
- Packet length: `((last_addr - first_addr) mod 2^ADDR_WIDTH) + 1`.
  - Address wraps from 2^ADDR_WIDTH-1 to 0.
  - `first_addr == last_addr` means a 1-word packet.
  - A full-memory packet of 256 words (ADDR_WIDTH=8) is possible when `last_addr == first_addr-1`.
- Read issue: a 2-entry output buffer holds words returned by the SRAM.
  - A read is issued when `(entries + reads_in_flight - pop_this_cycle) < 2` and reads issued < packet length.
  - `sram_rd` is never asserted for an address beyond the packet.
- Emission: `out_wr = buffer_not_empty & out_rdy`, combinational on `out_rdy`.
  - `out_data`/`out_ctrl` always show the buffer head.
  - Ctrl/data pass through unmodified.
- `word_count` increments on each `out_wr`.
- RUN goes to DONE in the cycle after the word-count-th `out_wr` equals the packet length.
- `eop_err` is evaluated on the last emitted word's ctrl.
- `start` while `busy` or in DONE is ignored; no queuing.
- If `out_rdy` is low, the buffer fills, reads stall, and `sram_addr` holds its value. No word is dropped or duplicated.

## Timing
- Reset values:
  - `busy`, `done`, `eop_err`, `sram_rd`, `out_wr` = 0.
  - `sram_addr`, `word_count`, `out_data`, `out_ctrl` = 0.
  - state = IDLE, buffer empty, in-flight count = 0.
- Reset mid-packet: returns to IDLE next cycle.
  - The in-flight SRAM return is discarded.
  - `done` is not pulsed.
- Latency: with `start` sampled at cycle 0:
  - `sram_rd=1`, `sram_addr=first_addr` at cycle 1.
  - Data is buffered at the end of cycle 2.
  - First `out_wr` is possible at cycle 3.
- Throughput: 1 word/cycle while `out_rdy` is held high.
- N-word packet with `out_rdy` constantly high: `out_wr` in cycles 3..N+2; `done` in cycle N+3.
- Earliest next `start` is accepted in cycle N+4.

## Test plan
- 4-word packet, `first_addr=8'h10`, `last_addr=8'h13`, `out_rdy=1`:
  - `sram_addr` 10,11,12,13 in cycles 1..4.
  - `out_wr` in cycles 3..6 with matching words.
  - `done` at cycle 7, `word_count=4`.
- 1-word packet, `first_addr=last_addr=8'h20`, SRAM ctrl=8'h00:
  - Exactly one `sram_rd` and one `out_wr`.
  - `done` and `eop_err` both pulse in cycle 4.
- Wrap: `first_addr=8'hFE`, `last_addr=8'h01`:
  - Reads FE,FF,00,01.
  - 4 `out_wr`; `word_count=4`.
- Backpressure: 8-word packet with `out_rdy` toggling 1,0,0,1,...:
  - Output sequence equals SRAM contents in order.
  - Buffer never exceeds 2 entries.
  - No `out_wr` while `out_rdy=0`.
- `start` pulsed during RUN with different addresses: ignored.
  - The original packet completes unchanged.
  - `done` pulses once.
- `rst_n=0` during word 3 of a 6-word packet:
  - Next cycle all outputs are 0 and state is IDLE.
  - No `done`.
  - A new `start` afterwards runs cleanly from its `first_addr`.
